// File: rtl/and_gate.sv
// and_gate: bitwise two-input AND with a zero-latency result, a registered
// copy, per-bit rising-edge pulses of the registered copy, and a saturating
// count of cycles on which the result is all ones.
//
// There is no handshake on this block: inputs are sampled on every rising
// clock edge and outputs are valid continuously (out) or from the edge that
// produced them (out_q, rise, hit_cnt).
module and_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] rise,
    output logic [CNT_W-1:0] hit_cnt,
    input  logic             clr
);

    // Counter ceiling; the count holds here instead of wrapping to zero.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic all_ones;
    logic cnt_full;

    // Zero-latency result; independent of clock and reset so it stays
    // meaningful while the registered views are held in reset.
    assign out      = in0 & in1;
    assign all_ones = &out;
    assign cnt_full = (hit_cnt == CNT_MAX);

    // Registered copy of out, plus a pulse for each bit that goes 0->1.
    // rise compares against the old out_q, so it lands on the same edge
    // that first loads a 1 into out_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            rise  <= '0;
        end else begin
            out_q <= out;
            rise  <= out & ~out_q;
        end
    end

    // Saturating hit counter; clr has priority over a coincident hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (clr) begin
            hit_cnt <= '0;
        end else if (all_ones && !cnt_full) begin
            hit_cnt <= hit_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_and_gate.sv
// tb_and_gate: directed bench for and_gate. Three instances cover the default
// configuration, a 2-bit counter for saturation, and a 4-bit data path.
// Expected values are pushed to exp_q when stimulus is driven and popped when
// the corresponding DUT output is sampled.
module tb_and_gate;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic       a0, b0, clr0, out0, outq0, rise0;
    logic [7:0] hit0;
    logic       a1, b1, clr1, out1, outq1, rise1;
    logic [1:0] hit1;
    logic [3:0] a2, b2, out2, outq2, rise2;
    logic       clr2;
    logic [7:0] hit2;

    and_gate #(.WIDTH(1), .CNT_W(8)) u_dflt (
        .clk(clk), .rst_n(rst_n), .in0(a0), .in1(b0), .out(out0),
        .out_q(outq0), .rise(rise0), .hit_cnt(hit0), .clr(clr0)
    );

    and_gate #(.WIDTH(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in0(a1), .in1(b1), .out(out1),
        .out_q(outq1), .rise(rise1), .hit_cnt(hit1), .clr(clr1)
    );

    and_gate #(.WIDTH(4), .CNT_W(8)) u_wide (
        .clk(clk), .rst_n(rst_n), .in0(a2), .in1(b2), .out(out2),
        .out_q(outq2), .rise(rise2), .hit_cnt(hit2), .clr(clr2)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check_pop(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s observed=%0h expected=<queue empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
            end
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    logic [1:0] pat;
    logic [1:0] sweep [5];

    initial begin
        sweep[0] = 2'b00; sweep[1] = 2'b01; sweep[2] = 2'b10;
        sweep[3] = 2'b11; sweep[4] = 2'b00;

        rst_n = 1'b0;
        a0 = 0; b0 = 0; clr0 = 0;
        a1 = 0; b1 = 0; clr1 = 0;
        a2 = '0; b2 = '0; clr2 = 0;

        // Reset state with inputs 00
        push(0); push(0); push(0); push(0);
        #100;
        check_pop("reset_out", out0);
        check_pop("reset_out_q", outq0);
        check_pop("reset_rise", rise0);
        check_pop("reset_hit_cnt", hit0);

        // Truth table sweep, combinational and valid during reset
        for (int i = 0; i < 5; i++) begin
            pat = sweep[i];
            push({31'b0, pat[1] & pat[0]});
            a0 = pat[1];
            b0 = pat[0];
            #5;
            check_pop($sformatf("sweep_%0d%0d", pat[1], pat[0]), out0);
        end

        // Release reset and hold 11 for three edges
        @(negedge clk);
        rst_n = 1'b1;
        a0 = 1; b0 = 1;
        edge_sample();
        push(1); push(1); push(1);
        check_pop("e1_out_q", outq0);
        check_pop("e1_rise", rise0);
        check_pop("e1_hit", hit0);
        edge_sample();
        push(0); push(2);
        check_pop("e2_rise", rise0);
        check_pop("e2_hit", hit0);
        edge_sample();
        push(0); push(3);
        check_pop("e3_rise", rise0);
        check_pop("e3_hit", hit0);
        edge_sample();
        edge_sample();
        push(5);
        check_pop("e5_hit", hit0);

        // Asynchronous reset between edges discards the count
        #2;
        rst_n = 1'b0;
        #1;
        push(0); push(0); push(0); push(1);
        check_pop("async_out_q", outq0);
        check_pop("async_rise", rise0);
        check_pop("async_hit", hit0);
        check_pop("async_out", out0);
        a0 = 0;
        #1;
        push(0);
        check_pop("async_out_track", out0);

        // Saturation with a 2-bit counter
        @(negedge clk);
        rst_n = 1'b1;
        a1 = 1; b1 = 1;
        for (int i = 0; i < 6; i++) edge_sample();
        push(3);
        check_pop("sat_hit", hit1);
        @(negedge clk);
        clr1 = 1;
        edge_sample();
        push(0);
        check_pop("clr_wins", hit1);
        @(negedge clk);
        clr1 = 0;
        edge_sample();
        push(1);
        check_pop("after_clr", hit1);

        // 4-bit data path
        @(negedge clk);
        a2 = 4'b1100; b2 = 4'b1010;
        #1;
        push(4'b1000);
        check_pop("w_out", out2);
        edge_sample();
        push(0); push(4'b1000); push(4'b1000);
        check_pop("w_hit_hold", hit2);
        check_pop("w_out_q", outq2);
        check_pop("w_rise", rise2);
        @(negedge clk);
        a2 = 4'b1111; b2 = 4'b1111;
        edge_sample();
        push(1); push(4'b0111); push(4'b1111);
        check_pop("w_hit_inc", hit2);
        check_pop("w_rise2", rise2);
        check_pop("w_out_q2", outq2);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL leftover observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
